// File: rtl/nanorv32_pmux_pkg.sv
// nanorv32_pmux_pkg: register offsets, AFSEL encodings and the per-pin output selector
package nanorv32_pmux_pkg;
  localparam logic [4:0] PMUX_DIR    = 5'h00;
  localparam logic [4:0] PMUX_OUT    = 5'h04;
  localparam logic [4:0] PMUX_IN     = 5'h08;
  localparam logic [4:0] PMUX_AFSEL  = 5'h0C;
  localparam logic [4:0] PMUX_IRQEN  = 5'h10;
  localparam logic [4:0] PMUX_IRQST  = 5'h14;
  localparam logic [4:0] PMUX_IRQPOL = 5'h18;
  localparam logic [31:0] PMUX_REG_RST = 32'h0;
  typedef enum logic [1:0] {
    PMUX_AF_GPIO = 2'd0,
    PMUX_AF_AF1  = 2'd1,
    PMUX_AF_AF2  = 2'd2,
    PMUX_AF_OFF  = 2'd3
  } af_sel_e;
  function automatic logic pmux_pick(logic [1:0] s, logic gpio, logic af1, logic af2);
    return s == PMUX_AF_GPIO ? gpio : s == PMUX_AF_AF1 ? af1 : s == PMUX_AF_AF2 ? af2 : 1'b0;
  endfunction
endpackage

// File: rtl/nanorv32_pmux_sync_filter.sv
// nanorv32_pmux_sync_filter: one pin's 2-flop synchroniser, input-enable gate and
// optional glitch filter (built when PMUX_GLITCH_FILTER_EN is defined)
module nanorv32_pmux_sync_filter #(
  parameter int FILT_CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic ie,
  output logic q
);
  logic s1, s2, lvl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  assign lvl = s2 & ie;
`ifdef PMUX_GLITCH_FILTER_EN
  logic [FILT_CNT_W-1:0] cnt;
  // q follows lvl only after it has disagreed for 2**FILT_CNT_W consecutive samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      q <= 1'b0;
    end else if (lvl == q) cnt <= '0;
    else if (&cnt) begin
      cnt <= '0;
      q <= lvl;
    end else cnt <= cnt + 1'b1;
`else
  assign q = lvl;
`endif
  if (FILT_CNT_W < 1) begin : g_bad_cnt_w
    $error("nanorv32_pmux_sync_filter: FILT_CNT_W must be at least 1");
  end
endmodule

// File: rtl/nanorv32_pmux.sv
// nanorv32_pmux: port-A pin mux, GPIO and edge interrupts behind APB.
// Define PMUX_GLITCH_FILTER_EN to add a per-pin glitch filter on the input path.
module nanorv32_pmux
  import nanorv32_pmux_pkg::*;
#(
  parameter int W = 16,
  parameter int FILT_CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [4:0]    paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  input  logic [W-1:0]  af1_dout,
  input  logic [W-1:0]  af1_oe,
  input  logic [W-1:0]  af2_dout,
  input  logic [W-1:0]  af2_oe,
  output logic [W-1:0]  pmux_af_din,
  output logic [W-1:0]  pmux_pad_dout,
  output logic [W-1:0]  pmux_pad_oe,
  output logic [W-1:0]  pmux_pad_ie,
  input  logic [W-1:0]  pad_pmux_din,
  output logic          pmux_irq
);
  logic [W-1:0] dir, gpio_out, irqen, irqst, irqpol, in_q, in_prev, edge_set, st_clr;
  logic [W-1:0] dout_n, oe_n, ie_n;
  logic [2*W-1:0] afsel;
  logic wr;
  assign wr = psel & penable & pwrite;
  assign pready = 1'b1;
  assign pmux_af_din = in_q;
  for (genvar g = 0; g < W; g++) begin : g_pin
    nanorv32_pmux_sync_filter #(.FILT_CNT_W(FILT_CNT_W)) u_sf (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pad_pmux_din[g]),
      .ie    (pmux_pad_ie[g]),
      .q     (in_q[g])
    );
  end
  always_comb begin
    dout_n = '0;
    oe_n = '0;
    ie_n = '0;
    for (int i = 0; i < W; i++) begin
      dout_n[i] = pmux_pick(afsel[2*i +: 2], gpio_out[i], af1_dout[i], af2_dout[i]);
      oe_n[i] = pmux_pick(afsel[2*i +: 2], dir[i], af1_oe[i], af2_oe[i]);
      ie_n[i] = afsel[2*i +: 2] != PMUX_AF_OFF;
    end
  end
  // A bit flags when it changed towards its polarity: new level differs from IRQPOL
  assign edge_set = (in_q ^ in_prev) & (in_q ^ irqpol);
  assign st_clr = (wr && paddr == PMUX_IRQST) ? pwdata[W-1:0] : '0;
  assign prdata = paddr == PMUX_DIR    ? 32'(dir) :
                  paddr == PMUX_OUT    ? 32'(gpio_out) :
                  paddr == PMUX_IN     ? 32'(in_q) :
                  paddr == PMUX_AFSEL  ? 32'(afsel) :
                  paddr == PMUX_IRQEN  ? 32'(irqen) :
                  paddr == PMUX_IRQST  ? 32'(irqst) :
                  paddr == PMUX_IRQPOL ? 32'(irqpol) : 32'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dir <= PMUX_REG_RST[W-1:0];
      gpio_out <= PMUX_REG_RST[W-1:0];
      afsel <= PMUX_REG_RST[2*W-1:0];
      irqen <= PMUX_REG_RST[W-1:0];
      irqst <= PMUX_REG_RST[W-1:0];
      irqpol <= PMUX_REG_RST[W-1:0];
      in_prev <= '0;
      pmux_irq <= 1'b0;
      pmux_pad_dout <= '0;
      pmux_pad_oe <= '0;
      pmux_pad_ie <= '1;
    end else begin
      if (wr && paddr == PMUX_DIR) dir <= pwdata[W-1:0];
      if (wr && paddr == PMUX_OUT) gpio_out <= pwdata[W-1:0];
      if (wr && paddr == PMUX_AFSEL) afsel <= pwdata[2*W-1:0];
      if (wr && paddr == PMUX_IRQEN) irqen <= pwdata[W-1:0];
      if (wr && paddr == PMUX_IRQPOL) irqpol <= pwdata[W-1:0];
      irqst <= (irqst & ~st_clr) | edge_set;
      in_prev <= in_q;
      pmux_irq <= |(irqst & irqen);
      pmux_pad_dout <= dout_n;
      pmux_pad_oe <= oe_n;
      pmux_pad_ie <= ie_n;
    end
endmodule

// File: tb/tb_nanorv32_pmux.sv
// tb_nanorv32_pmux: vector table, directed corner sequences and a randomized run against a reference model
module tb_nanorv32_pmux;
  localparam int W = 16;
`ifdef PMUX_GLITCH_FILTER_EN
  localparam int FD = 4;
`else
  localparam int FD = 0;
`endif
  localparam int LAT = 2 + FD;
  logic clk = 1'b0, rst_n = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata, rd;
  logic pready, pmux_irq;
  logic [W-1:0] af1_dout = '0, af1_oe = '0, af2_dout = '0, af2_oe = '0, pad_pmux_din = '0;
  logic [W-1:0] pmux_af_din, pmux_pad_dout, pmux_pad_oe, pmux_pad_ie;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  nanorv32_pmux dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .af1_dout(af1_dout), .af1_oe(af1_oe), .af2_dout(af2_dout), .af2_oe(af2_oe),
    .pmux_af_din(pmux_af_din), .pmux_pad_dout(pmux_pad_dout), .pmux_pad_oe(pmux_pad_oe),
    .pmux_pad_ie(pmux_pad_ie), .pad_pmux_din(pad_pmux_din), .pmux_irq(pmux_irq)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask
  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1 d = prdata;
    psel = 1'b0;
  endtask
  // Reference model: registers as plain words, the synchroniser as a two-deep
  // delay line and the filter as "the last 2**FILT_CNT_W samples all disagree".
  logic [W-1:0] m_dir, m_out, m_irqen, m_irqst, m_irqpol, m_dout, m_oe, m_ie;
  logic [W-1:0] m_inf, m_prev, m_s1, m_s2;
  logic [W-1:0] m_hist [4];
  logic [2*W-1:0] m_afsel;
  logic m_irq;
  function automatic logic [W-1:0] cur_in();
    return FD == 0 ? (m_s2 & m_ie) : m_inf;
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'h00: return 32'(m_dir);
      5'h04: return 32'(m_out);
      5'h08: return 32'(cur_in());
      5'h0C: return 32'(m_afsel);
      5'h10: return 32'(m_irqen);
      5'h14: return 32'(m_irqst);
      5'h18: return 32'(m_irqpol);
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_reset();
    {m_dir, m_out, m_irqen, m_irqst, m_irqpol, m_dout, m_oe} = '0;
    {m_inf, m_prev, m_s1, m_s2, m_afsel, m_irq} = '0;
    m_ie = '1;
    for (int k = 0; k < 4; k++) m_hist[k] = '0;
  endtask
  task automatic model_tick();
    logic [W-1:0] in_now, lvl, clr, nd, no, ni, nst;
    logic wr;
    in_now = cur_in();
    lvl = m_s2 & m_ie;
    wr = psel & penable & pwrite;
    clr = (wr && paddr == 5'h14) ? pwdata[W-1:0] : '0;
    for (int i = 0; i < W; i++) begin
      logic rose, fell;
      rose = in_now[i] && !m_prev[i];
      fell = !in_now[i] && m_prev[i];
      nst[i] = (m_irqst[i] && !clr[i]) || (m_irqpol[i] ? fell : rose);
      case (m_afsel[2*i +: 2])
        2'd0: begin nd[i] = m_out[i]; no[i] = m_dir[i]; ni[i] = 1'b1; end
        2'd1: begin nd[i] = af1_dout[i]; no[i] = af1_oe[i]; ni[i] = 1'b1; end
        2'd2: begin nd[i] = af2_dout[i]; no[i] = af2_oe[i]; ni[i] = 1'b1; end
        default: begin nd[i] = 1'b0; no[i] = 1'b0; ni[i] = 1'b0; end
      endcase
    end
    m_irq = |(m_irqst & m_irqen);
    m_irqst = nst;
    m_prev = in_now;
    if (FD != 0) begin
      m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = lvl;
      for (int i = 0; i < W; i++)
        if (m_hist[0][i] != m_inf[i] && m_hist[1][i] != m_inf[i] &&
            m_hist[2][i] != m_inf[i] && m_hist[3][i] != m_inf[i]) m_inf[i] = ~m_inf[i];
    end
    m_s2 = m_s1;
    m_s1 = pad_pmux_din;
    m_dout = nd; m_oe = no; m_ie = ni;
    if (wr)
      case (paddr)
        5'h00: m_dir = pwdata[W-1:0];
        5'h04: m_out = pwdata[W-1:0];
        5'h0C: m_afsel = pwdata[2*W-1:0];
        5'h10: m_irqen = pwdata[W-1:0];
        5'h18: m_irqpol = pwdata[W-1:0];
        default: ;
      endcase
  endtask
  typedef struct {
    logic [4:0]  a;
    logic        wr;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[15];
  logic seen;
  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{a: 5'(i * 4), wr: 1'b0, d: 32'h0, exp: 32'h0};
    tbl[8]  = '{a: 5'h00, wr: 1'b1, d: 32'hFFFF_00FF, exp: 32'h0000_00FF};
    tbl[9]  = '{a: 5'h04, wr: 1'b1, d: 32'h0000_00A5, exp: 32'h0000_00A5};
    tbl[10] = '{a: 5'h18, wr: 1'b1, d: 32'h0000_0020, exp: 32'h0000_0020};
    tbl[11] = '{a: 5'h10, wr: 1'b1, d: 32'h0000_0008, exp: 32'h0000_0008};
    tbl[12] = '{a: 5'h08, wr: 1'b1, d: 32'h0000_FFFF, exp: 32'h0};
    tbl[13] = '{a: 5'h1C, wr: 1'b1, d: 32'h0000_1234, exp: 32'h0};
    tbl[14] = '{a: 5'h14, wr: 1'b1, d: 32'h0000_FFFF, exp: 32'h0};
    #12;
    chk("rst_oe", 32'(pmux_pad_oe), 32'h0);
    chk("rst_ie", 32'(pmux_pad_ie), 32'hFFFF);
    chk("rst_dout", 32'(pmux_pad_dout), 32'h0);
    chk("rst_irq", 32'(pmux_irq), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].a, tbl[i].d);
      apb_rd(tbl[i].a, rd);
      chk($sformatf("tbl%0d_addr%h", i, tbl[i].a), rd, tbl[i].exp);
    end
    tick(1);
    chk("gpio_oe", 32'(pmux_pad_oe), 32'h00FF);
    chk("gpio_dout", 32'(pmux_pad_dout), 32'h00A5);
    chk("gpio_ie", 32'(pmux_pad_ie), 32'hFFFF);
    apb_wr(5'h0C, 32'h1);
    tick(1);
    chk("af1_dout_lo", 32'(pmux_pad_dout), 32'h00A4);
    chk("af1_oe_lo", 32'(pmux_pad_oe), 32'h00FE);
    af1_dout = 16'h1; af1_oe = 16'h1;
    tick(1);
    chk("af1_dout_hi", 32'(pmux_pad_dout), 32'h00A5);
    chk("af1_oe_hi", 32'(pmux_pad_oe), 32'h00FF);
    apb_wr(5'h0C, 32'h9);
    af2_dout = 16'h2; af2_oe = 16'h0;
    tick(1);
    chk("af2_dout", 32'(pmux_pad_dout), 32'h00A7);
    chk("af2_oe", 32'(pmux_pad_oe), 32'h00FD);
    apb_wr(5'h0C, 32'h0);
    {af1_dout, af1_oe, af2_dout, af2_oe} = '0;
    // pin3 rising edge with IRQEN=0x8
    pad_pmux_din[3] = 1'b1;
    tick(LAT - 1);
    chk("in3_early", 32'(pmux_af_din), 32'h0);
    tick(1);
    chk("in3_lat", 32'(pmux_af_din), 32'h8);
    chk("irq_before_st", 32'(pmux_irq), 32'h0);
    tick(1);
    apb_rd(5'h14, rd);
    chk("irqst3", rd, 32'h8);
    chk("irq_same_clk", 32'(pmux_irq), 32'h0);
    tick(1);
    chk("irq_set", 32'(pmux_irq), 32'h1);
    apb_wr(5'h14, 32'h8);
    apb_rd(5'h14, rd);
    chk("irqst3_w1c", rd, 32'h0);
    chk("irq_lag", 32'(pmux_irq), 32'h1);
    tick(1);
    chk("irq_clr", 32'(pmux_irq), 32'h0);
    // pin5 with falling polarity
    pad_pmux_din[5] = 1'b1;
    tick(LAT + 2);
    apb_rd(5'h14, rd);
    chk("pol5_rise", rd, 32'h0);
    pad_pmux_din[5] = 1'b0;
    tick(LAT);
    apb_rd(5'h14, rd);
    chk("pol5_fall_early", rd, 32'h0);
    tick(1);
    apb_rd(5'h14, rd);
    chk("pol5_fall", rd, 32'h20);
    pad_pmux_din[5] = 1'b1;
    tick(LAT + 2);
    pad_pmux_din[5] = 1'b0;
    tick(LAT - 1);
    apb_wr(5'h14, 32'h20);
    apb_rd(5'h14, rd);
    chk("w1c_vs_set", rd, 32'h20);
    apb_wr(5'h14, 32'h20);
    apb_rd(5'h14, rd);
    chk("w1c_plain", rd, 32'h0);
    // pin2 short pulses
`ifdef PMUX_GLITCH_FILTER_EN
    pad_pmux_din[2] = 1'b1;
    tick(3);
    pad_pmux_din[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen |= pmux_af_din[2];
    end
    chk("glitch3_blocked", 32'(seen), 32'h0);
    pad_pmux_din[2] = 1'b1;
    tick(5);
    chk("pulse6_early", 32'(pmux_af_din[2]), 32'h0);
    tick(1);
    chk("pulse6_pass", 32'(pmux_af_din[2]), 32'h1);
    pad_pmux_din[2] = 1'b0;
    tick(10);
    chk("pulse6_return", 32'(pmux_af_din[2]), 32'h0);
`else
    pad_pmux_din[2] = 1'b1;
    tick(1);
    pad_pmux_din[2] = 1'b0;
    chk("pulse1_pre", 32'(pmux_af_din[2]), 32'h0);
    tick(1);
    chk("pulse1_pass", 32'(pmux_af_din[2]), 32'h1);
    tick(1);
    chk("pulse1_end", 32'(pmux_af_din[2]), 32'h0);
`endif
    // pin7 disabled
    pad_pmux_din[7] = 1'b1;
    tick(LAT + 1);
    chk("in7_high", 32'(pmux_af_din[7]), 32'h1);
    apb_wr(5'h0C, 32'hC000);
    tick(1);
    chk("off7_ie", 32'(pmux_pad_ie), 32'hFF7F);
    chk("off7_oe", 32'(pmux_pad_oe), 32'h007F);
    tick(FD);
    chk("off7_in", 32'(pmux_af_din[7]), 32'h0);
    apb_wr(5'h10, 32'hFFFF);
    tick(1);
    chk("irq_pre_rst", 32'(pmux_irq), 32'h1);
    // asynchronous reset in the middle of an APB write
    psel = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h1234;
    @(posedge clk); #1 penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(pmux_pad_oe), 32'h0);
    chk("arst_dout", 32'(pmux_pad_dout), 32'h0);
    chk("arst_ie", 32'(pmux_pad_ie), 32'hFFFF);
    chk("arst_irq", 32'(pmux_irq), 32'h0);
    chk("arst_in", 32'(pmux_af_din), 32'h0);
    chk("arst_prdata", prdata, 32'h0);
    {psel, penable, pwrite} = '0;
    pad_pmux_din = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) pad_pmux_din[i] = ~pad_pmux_din[i];
      af1_dout = W'($urandom); af1_oe = W'($urandom);
      af2_dout = W'($urandom); af2_oe = W'($urandom);
      psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
      paddr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7) * 4);
      pwdata = $urandom;
      #1;
      if (psel && !pwrite) chk($sformatf("rnd_rd_%h", paddr), prdata, m_read(paddr));
      model_tick();
      @(posedge clk); #1;
      chk("rnd_dout", 32'(pmux_pad_dout), 32'(m_dout));
      chk("rnd_oe", 32'(pmux_pad_oe), 32'(m_oe));
      chk("rnd_ie", 32'(pmux_pad_ie), 32'(m_ie));
      chk("rnd_in", 32'(pmux_af_din), 32'(cur_in()));
      chk("rnd_irq", 32'(pmux_irq), 32'(m_irq));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
